pl_reg_stage: RTL and testbench

Parametrised, flow-controlled pipeline stage register that replaces the fixed, always-enabled inter-stage registers between the RISC-V core stages. Carries an opaque WIDTH-bit payload: the stage's control and data fields concatenated. It adds a valid/ready handshake, a synchronous flush, and an optional two-entry skid buffer, so stalls and branch/hazard squashes are handled in the register itself. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pl_reg_stage.sv | 70 +++++++
 tb/tb_pl_reg_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pl_reg_stage.sv
// pl_reg_stage: flow-controlled pipeline register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
module pl_reg_stage #(
   parameter int WIDTH          = 32,
   parameter bit SKID           = 1'b1,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] main_d, skid_d, main_n, skid_n;
   logic ready_q, main_v, skid_v, push, pop;
   assign main_v    = state != EMPTY;
   assign skid_v    = state == FULL;
   assign in_ready  = SKID ? ready_q : (!main_v || out_ready);
   assign push      = in_valid && in_ready;
   assign pop       = main_v && out_ready;
   assign out_valid = main_v;
   assign out_data  = main_d;
   assign count     = {1'b0, main_v} + {1'b0, skid_v};
   // FULL is only reachable with SKID=1: in SKID=0 a push into a held entry implies a pop
   always_comb begin
      state_n = state;
      main_n  = main_d;
      skid_n  = skid_d;
      if (flush) begin
         state_n = EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_n = '0;
            skid_n = '0;
         end
      end else if (state == FULL) begin
         if (pop) begin
            state_n = ONE;
            main_n  = skid_d;
         end
      end else if (SKID && push && main_v && !pop) begin
         state_n = FULL;
         skid_n  = in_data;
      end else if (push) begin
         state_n = ONE;
         main_n  = in_data;
      end else if (pop) begin
         state_n = EMPTY;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         main_d  <= '0;
         skid_d  <= '0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_n;
         main_d  <= main_n;
         skid_d  <= skid_n;
         ready_q <= state_n != FULL;
      end
   end
endmodule

// File: tb/tb_pl_reg_stage.sv
// tb_pl_reg_stage: drives a SKID=1 instance [0] and a SKID=0 instance [1]; a
// reference FIFO per instance is filled on accepted pushes and checked on pops.
module tb_pl_reg_stage;
   logic clk = 1'b0;
   logic rst_n;
   logic iv[2], ir[2], fl[2], ov[2], ordy[2];
   logic [7:0] id[2], od[2];
   logic [1:0] cnt[2];
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      pl_reg_stage #(.WIDTH(8), .SKID(g == 0), .CLEAR_ON_FLUSH(1'b1)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
         .flush(fl[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]), .count(cnt[g])
      );
      logic [7:0] q[$];
      logic stall = 1'b0;
      logic [7:0] prev = '0;
      // reference model: ready follows queue occupancy, acceptance decided by the bench
      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            stall = 1'b0;
         end else begin
            automatic int n = q.size();
            automatic logic er = (g == 0) ? (n < 2) : (n == 0 || ordy[g]);
            chk($sformatf("in_ready[%0d]", g), {31'b0, ir[g]}, {31'b0, er});
            chk($sformatf("out_valid[%0d]", g), {31'b0, ov[g]}, {31'b0, n != 0});
            chk($sformatf("count[%0d]", g), {30'b0, cnt[g]}, n);
            if (stall) chk($sformatf("stable[%0d]", g), {24'b0, od[g]}, {24'b0, prev});
            stall = n != 0 && !ordy[g] && !fl[g];
            prev = od[g];
            if (n != 0 && ordy[g]) chk($sformatf("data[%0d]", g), {24'b0, od[g]}, {24'b0, q.pop_front()});
            if (fl[g]) q.delete();
            else if (iv[g] && er) q.push_back(id[g]);
         end
      end
   end

   task automatic drive(input int i, input logic v, input logic [7:0] d, input logic r, input logic f);
      iv[i] = v;
      id[i] = d;
      ordy[i] = r;
      fl[i] = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 1, 0);
      drive(1, 0, 8'h00, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", {31'b0, ov[i]}, 0);
         chk("rst_data", {24'b0, od[i]}, 0);
         chk("rst_count", {30'b0, cnt[i]}, 0);
         chk("rst_ready", {31'b0, ir[i]}, 1);
      end
      rst_n = 1'b1;
      tick();
      // streaming at full rate
      drive(0, 1, 8'h11, 1, 0); tick();
      chk("s_d11", {24'b0, od[0]}, 32'h11); chk("s_c1", {30'b0, cnt[0]}, 1);
      drive(0, 1, 8'h22, 1, 0); tick();
      chk("s_d22", {24'b0, od[0]}, 32'h22); chk("s_r1", {31'b0, ir[0]}, 1);
      drive(0, 1, 8'h33, 1, 0); tick();
      chk("s_d33", {24'b0, od[0]}, 32'h33); chk("s_c1b", {30'b0, cnt[0]}, 1);
      drive(0, 0, 8'h00, 1, 0); tick();
      // skid absorbs one push after stall begins
      drive(0, 1, 8'hA1, 1, 0); tick();
      drive(0, 1, 8'hA2, 0, 0); tick();
      chk("k_c2", {30'b0, cnt[0]}, 2); chk("k_r0", {31'b0, ir[0]}, 0);
      drive(0, 1, 8'hA3, 0, 0); tick();
      chk("k_hold", {24'b0, od[0]}, 32'hA1); chk("k_c2b", {30'b0, cnt[0]}, 2);
      tick();
      drive(0, 1, 8'hA3, 1, 0); tick();
      chk("k_dA2", {24'b0, od[0]}, 32'hA2); chk("k_r1", {31'b0, ir[0]}, 1);
      tick();
      chk("k_dA3", {24'b0, od[0]}, 32'hA3);
      drive(0, 0, 8'h00, 1, 0); tick();
      chk("k_empty", {31'b0, ov[0]}, 0);
      // flush while FULL drops the concurrent push and clears payload
      drive(0, 1, 8'hB1, 0, 0); tick();
      drive(0, 1, 8'hB2, 0, 0); tick();
      drive(0, 1, 8'hB3, 0, 1); tick();
      chk("f_valid", {31'b0, ov[0]}, 0); chk("f_count", {30'b0, cnt[0]}, 0);
      chk("f_ready", {31'b0, ir[0]}, 1); chk("f_data", {24'b0, od[0]}, 0);
      drive(0, 0, 8'h00, 1, 0); tick();
      chk("f_noB3", {31'b0, ov[0]}, 0);
      // SKID=0 combinational ready
      drive(1, 1, 8'hC1, 0, 0); tick();
      chk("z_dC1", {24'b0, od[1]}, 32'hC1);
      drive(1, 0, 8'h00, 0, 0); #1;
      chk("z_r0", {31'b0, ir[1]}, 0);
      drive(1, 1, 8'hC2, 1, 0); #1;
      chk("z_r1", {31'b0, ir[1]}, 1);
      tick();
      chk("z_dC2", {24'b0, od[1]}, 32'hC2); chk("z_v", {31'b0, ov[1]}, 1);
      drive(1, 0, 8'h00, 1, 0); tick();
      // asynchronous reset while holding two entries
      drive(0, 1, 8'hE1, 0, 0); tick();
      drive(0, 1, 8'hE2, 0, 0); tick();
      drive(0, 0, 8'h00, 0, 0);
      chk("a_c2", {30'b0, cnt[0]}, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("a_valid", {31'b0, ov[0]}, 0); chk("a_data", {24'b0, od[0]}, 0);
      chk("a_count", {30'b0, cnt[0]}, 0);
      #3 rst_n = 1'b1;
      tick();
      drive(0, 1, 8'hD1, 0, 0); tick();
      chk("a_dD1", {24'b0, od[0]}, 32'hD1); chk("a_vD1", {31'b0, ov[0]}, 1);
      drive(0, 0, 8'h00, 1, 0); tick();
      // random traffic, checked by the reference FIFOs
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 2; i++)
            drive(i, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 15) == 0);
         tick();
      end
      drive(0, 0, 8'h00, 1, 0);
      drive(1, 0, 8'h00, 1, 0);
      repeat (4) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
